// File: rtl/imm_field_encoder.sv
// ---------------------------------------------------------------------------
// imm_field_encoder
//
// Inverse of the LEGv8 sign-extend unit: range-checks a 64-bit immediate
// against the field selected by a 2-bit format code, then inserts the
// (possibly truncated) field into a 32-bit base instruction word.
// Two register stages sit behind a valid/ready stream interface with full
// back-pressure. A saturating counter tracks how many errored results the
// consumer has taken.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   in_valid   in   request present
//   in_ready   out  request accepted when in_valid & in_ready
//   in_fmt     in   00 ALU imm, 01 DT address, 10 branch, 11 cond-branch
//   in_imm     in   immediate (two's complement for signed formats)
//   in_instr   in   base instruction word
//   out_valid  out  result present
//   out_ready  in   consumer accepts when out_valid & out_ready
//   out_instr  out  base word with field inserted
//   out_err    out  immediate did not fit the field
//   err_count  out  errored results consumed, saturating at all-ones
// ---------------------------------------------------------------------------
module imm_field_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [63:0]      in_imm,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    // Stage 1 holds the raw request exactly as accepted.
    logic        s1_valid;
    logic [1:0]  s1_fmt;
    logic [63:0] s1_imm;
    logic [31:0] s1_instr;

    // Result of the range check and field merge, computed from stage 1.
    logic [31:0] merged_instr;
    logic        range_err;

    logic s1_load;
    logic s2_load;

    // Stage 2 may take a new result when it is empty or being drained in
    // this same cycle, which is what allows a bubble-free drain + refill.
    assign s2_load  = s1_valid & (~out_valid | out_ready);

    // Held low during reset so nothing can be accepted while the
    // pipeline is being cleared.
    assign in_ready = ~reset & (~s1_valid | s2_load);
    assign s1_load  = in_valid & in_ready;

    // A signed field of width W fits when bits [63:W-1] are all equal,
    // i.e. the field's sign bit and every bit above it agree. Checking the
    // slice for all-ones or all-zeros covers both cases at once.
    always_comb begin
        merged_instr = s1_instr;
        range_err    = 1'b0;
        case (s1_fmt)
            2'b00: begin
                range_err    = |s1_imm[63:12];
                merged_instr = {s1_instr[31:22], s1_imm[11:0], s1_instr[9:0]};
            end
            2'b01: begin
                range_err    = ~((&s1_imm[63:8]) | ~(|s1_imm[63:8]));
                merged_instr = {s1_instr[31:21], s1_imm[8:0], s1_instr[11:0]};
            end
            2'b10: begin
                range_err    = ~((&s1_imm[63:25]) | ~(|s1_imm[63:25]));
                merged_instr = {s1_instr[31:26], s1_imm[25:0]};
            end
            default: begin
                range_err    = ~((&s1_imm[63:18]) | ~(|s1_imm[63:18]));
                merged_instr = {s1_instr[31:24], s1_imm[18:0], s1_instr[4:0]};
            end
        endcase
    end

    // Stage 1 register. Acceptance has priority over emptying because an
    // accept in the same cycle as an S1->S2 move simply replaces the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_fmt   <= 2'b00;
            s1_imm   <= 64'd0;
            s1_instr <= 32'd0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_fmt   <= in_fmt;
                s1_imm   <= in_imm;
                s1_instr <= in_instr;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 register driving the outputs. Data only changes on a load,
    // so a stalled result stays stable; valid drops once it is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                out_instr <= merged_instr;
                out_err   <= range_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Counts errored results as they are consumed, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (out_valid & out_ready & out_err & (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_field_encoder
//
// Directed-vector bench for imm_field_encoder. Expected results are pushed
// into a scoreboard queue when a request is accepted; a monitor pops and
// compares whenever the DUT hands over a result. The counter is narrowed to
// 3 bits so saturation is reachable with a handful of errored vectors.
// ---------------------------------------------------------------------------
module tb_imm_field_encoder;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_fmt;
    logic [63:0]      in_imm;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] err_count;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   exp_err_cnt;

    imm_field_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_imm    (in_imm),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Offers one request and waits (bounded) for it to be accepted, then
    // records the hand-computed expected result in the scoreboard.
    task automatic applyStimulus(input logic [1:0] fmt, input logic [63:0] imm,
                                 input logic [31:0] instr, input logic [31:0] exp_instr,
                                 input logic exp_err);
        bit   acc;
        exp_t e;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_fmt   = fmt;
        in_imm   = imm;
        in_instr = instr;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            e.instr = exp_instr;
            e.err   = exp_err;
            sb.push_back(e);
        end else begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
        end
    endtask

    // Waits until every expected result has been consumed, then lets the
    // final handshake edge pass so err_count reflects it.
    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a result counts as consumed when valid and ready are both
    // high, so compare against the oldest expected entry at that point.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 64'(out_instr), 64'hDEAD_0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("out_instr", 64'(out_instr), 64'(e.instr));
                checkOutput("out_err", 64'(out_err), 64'(e.err));
                if (e.err && exp_err_cnt < CNT_MAX) exp_err_cnt++;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stream of eight cond-branch requests with mixed signs and two
    // out-of-range values.
    logic [63:0] strm_imm [8];
    logic [31:0] strm_exp [8];
    logic        strm_err [8];

    initial begin
        strm_imm[0] = 64'h0;                strm_exp[0] = 32'hB400_0000; strm_err[0] = 1'b0;
        strm_imm[1] = 64'h1;                strm_exp[1] = 32'hB400_0020; strm_err[1] = 1'b0;
        strm_imm[2] = 64'hFFFF_FFFF_FFFF_FFFF; strm_exp[2] = 32'hB4FF_FFE0; strm_err[2] = 1'b0;
        strm_imm[3] = 64'hFFFF_FFFF_FFFC_0000; strm_exp[3] = 32'hB480_0000; strm_err[3] = 1'b0;
        strm_imm[4] = 64'h4_0000;           strm_exp[4] = 32'hB480_0000; strm_err[4] = 1'b1;
        strm_imm[5] = 64'h123;              strm_exp[5] = 32'hB400_2460; strm_err[5] = 1'b0;
        strm_imm[6] = 64'hFFFF_FFFF_FFFB_FFFF; strm_exp[6] = 32'hB47F_FFE0; strm_err[6] = 1'b1;
        strm_imm[7] = 64'h2A;               strm_exp[7] = 32'hB400_0540; strm_err[7] = 1'b0;
    end

    initial begin
        checks      = 0;
        errors      = 0;
        exp_err_cnt = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_fmt      = 2'b00;
        in_imm      = 64'd0;
        in_instr    = 32'd0;
        out_ready   = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
        checkOutput("rst_out_err", 64'(out_err), 64'd0);
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // ALU immediate in range, with a latency check: nothing yet right
        // after the accepting edge, result present after the next one.
        applyStimulus(2'b00, 64'h7FF, 32'h9100_0000, 32'h911F_FC00, 1'b0);
        checkOutput("lat_not_yet", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_present", 64'(out_valid), 64'd1);
        drain();

        // ALU immediate out of range: low bits are zero, error flagged.
        applyStimulus(2'b00, 64'h1000, 32'h9100_0000, 32'h9100_0000, 1'b1);
        drain();
        checkOutput("err_count_1", 64'(err_count), 64'(exp_err_cnt));
        checkOutput("err_count_1_const", 64'(err_count), 64'd1);

        // DT address, signed 9 bits.
        applyStimulus(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 32'hF840_0000, 32'hF85F_F000, 1'b0);
        applyStimulus(2'b01, 64'h100, 32'hF840_0000, 32'hF850_0000, 1'b1);

        // Branch, signed 26 bits. Bit 25 alone is +2^25, one past the top
        // of the range: the truncated bit 25 is still inserted.
        applyStimulus(2'b10, 64'hFFFF_FFFF_FE00_0000, 32'h1400_0000, 32'h1600_0000, 1'b0);
        applyStimulus(2'b10, 64'h0200_0000, 32'h1400_0000, 32'h1600_0000, 1'b1);
        applyStimulus(2'b10, 64'h0400_0000, 32'h1400_0000, 32'h1400_0000, 1'b1);

        // Cond-branch, signed 19 bits, largest positive value below bit 18.
        applyStimulus(2'b11, 64'h3FFFF, 32'hB400_0000, 32'hB47F_FFE0, 1'b0);
        drain();
        checkOutput("err_count_4", 64'(err_count), 64'(exp_err_cnt));

        // Eight back-to-back requests must come out on eight consecutive cycles.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    applyStimulus(2'b11, strm_imm[i], 32'hB400_0000, strm_exp[i], strm_err[i]);
            end
            begin
                for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    if (i > 0) @(negedge clk);
                    checkOutput("stream_consecutive", 64'(out_valid), 64'd1);
                end
            end
        join
        drain();
        checkOutput("err_count_6", 64'(err_count), 64'(exp_err_cnt));

        // Back-pressure: two requests fill the pipe, the third is held off.
        out_ready = 1'b0;
        applyStimulus(2'b00, 64'h1001, 32'h9100_0000, 32'h9100_0400, 1'b1);
        applyStimulus(2'b00, 64'hFFFF_FFFF_FFFF_F800, 32'h9100_0000, 32'h9120_0000, 1'b1);
        // Garbage offered while blocked must never be captured.
        in_valid = 1'b1;
        in_fmt   = 2'b10;
        in_imm   = 64'h3FF_FFFF;
        in_instr = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("full_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_out_instr", 64'(out_instr), 64'h9100_0400);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        applyStimulus(2'b00, 64'h5A5, 32'h9100_0000, 32'h9116_9400, 1'b0);
        drain();
        checkOutput("err_count_sat", 64'(err_count), 64'(CNT_MAX));
        checkOutput("err_count_sat_model", 64'(err_count), 64'(exp_err_cnt));

        // Reset with two requests in flight flushes everything.
        out_ready = 1'b0;
        applyStimulus(2'b01, 64'h0, 32'hF840_0000, 32'hF840_0000, 1'b0);
        applyStimulus(2'b01, 64'h200, 32'hF840_0000, 32'hF840_0000, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        exp_err_cnt = 0;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_err_count", 64'(err_count), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_stale_output", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(2'b01, 64'hFF, 32'hF840_0000, 32'hF84F_F000, 1'b0);
        drain();
        checkOutput("post_rst_err_count", 64'(err_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
